// File: rtl/ntt_pkg.sv
// Shared constants, types and helpers for the NTT/iNTT coefficient write-back path.
// Lane count, bank count and stage size are fixed by the butterfly array geometry.
package ntt_pkg;

   localparam int DATA_WIDTH = 12;
   localparam int NBANK      = 8;
   localparam int ADDR_W     = 5;
   localparam int BEATS      = 16;
   localparam int BANK_W     = 3;
   localparam int LANE_W     = 3;
   localparam int LG_W       = 3;
   localparam int CNT_W      = 4;

   typedef logic [DATA_WIDTH-1:0] coeff_t;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } wb_state_e;

   // Legal stage lengths are the powers of two from 2 to 128.
   function automatic logic len_is_legal(input logic [7:0] len);
      return (len >= 8'd2) && ((len & (len - 8'd1)) == 8'd0);
   endfunction

   function automatic logic [LG_W-1:0] len_log2(input logic [7:0] len);
      logic [LG_W-1:0] r;
      r = '0;
      for (int i = 1; i < 8; i++) begin
         if (len[i]) r = LG_W'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/bu_wb_addr_gen.sv
// Per-lane destination map: for stage length 2^lg_i and beat cnt_i, gives the
// bank, port (0 = A, 1 = B) and word address for the lane's X and Y results.
module bu_wb_addr_gen
   import ntt_pkg::*;
(
   input  logic [LG_W-1:0]   lg_i,
   input  logic [CNT_W-1:0]  cnt_i,
   input  logic [LANE_W-1:0] lane_i,
   output logic [BANK_W-1:0] x_bank_o,
   output logic              x_port_o,
   output logic [ADDR_W-1:0] x_addr_o,
   output logic [BANK_W-1:0] y_bank_o,
   output logic              y_port_o,
   output logic [ADDR_W-1:0] y_addr_o
);

   logic [LG_W-1:0]   shift;
   logic [ADDR_W-1:0] grp;
   logic [ADDR_W-1:0] base;
   logic [BANK_W-1:0] lo_bank;

   always_comb begin
      shift    = '0;
      grp      = '0;
      base     = '0;
      lo_bank  = '0;
      x_bank_o = '0;
      x_port_o = 1'b0;
      x_addr_o = '0;
      y_bank_o = '0;
      y_port_o = 1'b0;
      y_addr_o = '0;
      if (lg_i >= LG_W'(3)) begin
         // Pairs sit in the same bank, g = L/8 rows apart; beats walk g rows then skip g.
         shift    = lg_i - LG_W'(3);
         grp      = ADDR_W'(1) << shift;
         base     = ((ADDR_W'(cnt_i) >> shift) << (shift + LG_W'(1)))
                  | (ADDR_W'(cnt_i) & (grp - ADDR_W'(1)));
         x_bank_o = lane_i;
         x_port_o = 1'b0;
         x_addr_o = base;
         y_bank_o = lane_i;
         y_port_o = 1'b1;
         y_addr_o = base + grp;
      end else begin
         // Both halves of a pair share a row; lower lanes take the even row on port A.
         if (lg_i == LG_W'(2)) begin
            lo_bank  = {1'b0, lane_i[1:0]};
            y_bank_o = lo_bank | BANK_W'(4);
         end else begin
            lo_bank  = {lane_i[1], 1'b0, lane_i[0]};
            y_bank_o = lo_bank | BANK_W'(2);
         end
         x_bank_o = lo_bank;
         x_port_o = lane_i[2];
         x_addr_o = {cnt_i, lane_i[2]};
         y_port_o = lane_i[2];
         y_addr_o = {cnt_i, lane_i[2]};
      end
   end

endmodule

// File: rtl/bu_writeback.sv
// Butterfly write-back router: stage FSM, beat counter and registered crossbar
// steering 8 lanes of (X, Y) results onto the A/B ports of the 8 coefficient banks.
module bu_writeback
   import ntt_pkg::*;
(
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          start_i,
   input  logic [7:0]                    len_i,
   input  logic                          valid_i,
   input  logic [NBANK*DATA_WIDTH-1:0]   x_i,
   input  logic [NBANK*DATA_WIDTH-1:0]   y_i,
   output logic [NBANK-1:0]              wea_o,
   output logic [NBANK-1:0]              web_o,
   output logic [NBANK*ADDR_W-1:0]       addra_o,
   output logic [NBANK*ADDR_W-1:0]       addrb_o,
   output logic [NBANK*DATA_WIDTH-1:0]   dina_o,
   output logic [NBANK*DATA_WIDTH-1:0]   dinb_o,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          err_o
);

   wb_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [LG_W-1:0]   lg_q, lg_d;
   logic              err_q, err_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              we_q;
   logic              beat;
   logic              last_beat;

   logic [BANK_W-1:0] x_bank [NBANK];
   logic              x_port [NBANK];
   logic [ADDR_W-1:0] x_addr [NBANK];
   logic [BANK_W-1:0] y_bank [NBANK];
   logic              y_port [NBANK];
   logic [ADDR_W-1:0] y_addr [NBANK];

   coeff_t            dina_d  [NBANK];
   coeff_t            dinb_d  [NBANK];
   logic [ADDR_W-1:0] addra_d [NBANK];
   logic [ADDR_W-1:0] addrb_d [NBANK];
   coeff_t            dina_q  [NBANK];
   coeff_t            dinb_q  [NBANK];
   logic [ADDR_W-1:0] addra_q [NBANK];
   logic [ADDR_W-1:0] addrb_q [NBANK];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      lg_d      = lg_q;
      err_d     = err_q;
      beat      = 1'b0;
      last_beat = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               if (len_is_legal(len_i)) begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
                  lg_d    = len_log2(len_i);
                  err_d   = 1'b0;
               end else begin
                  err_d   = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (valid_i) begin
               beat      = 1'b1;
               cnt_d     = cnt_q + CNT_W'(1);
               last_beat = (cnt_q == CNT_W'(BEATS - 1));
               if (last_beat) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Busy covers the final write cycle, so it drops one cycle after done.
      busy_d = (state_d == ST_RUN) || last_beat;
      done_d = last_beat;
   end

   generate
      for (genvar gi = 0; gi < NBANK; gi++) begin : g_lane
         bu_wb_addr_gen u_addr_gen (
            .lg_i     (lg_q),
            .cnt_i    (cnt_q),
            .lane_i   (LANE_W'(gi)),
            .x_bank_o (x_bank[gi]),
            .x_port_o (x_port[gi]),
            .x_addr_o (x_addr[gi]),
            .y_bank_o (y_bank[gi]),
            .y_port_o (y_port[gi]),
            .y_addr_o (y_addr[gi])
         );
      end
   endgenerate

   // Each bank-port is hit by exactly one lane result per beat, so no priority is needed.
   always_comb begin
      for (int b = 0; b < NBANK; b++) begin
         dina_d[b]  = '0;
         dinb_d[b]  = '0;
         addra_d[b] = '0;
         addrb_d[b] = '0;
      end
      for (int m = 0; m < NBANK; m++) begin
         if (x_port[m]) begin
            dinb_d[x_bank[m]]  = x_i[m*DATA_WIDTH +: DATA_WIDTH];
            addrb_d[x_bank[m]] = x_addr[m];
         end else begin
            dina_d[x_bank[m]]  = x_i[m*DATA_WIDTH +: DATA_WIDTH];
            addra_d[x_bank[m]] = x_addr[m];
         end
         if (y_port[m]) begin
            dinb_d[y_bank[m]]  = y_i[m*DATA_WIDTH +: DATA_WIDTH];
            addrb_d[y_bank[m]] = y_addr[m];
         end else begin
            dina_d[y_bank[m]]  = y_i[m*DATA_WIDTH +: DATA_WIDTH];
            addra_d[y_bank[m]] = y_addr[m];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         lg_q    <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         we_q    <= 1'b0;
         for (int b = 0; b < NBANK; b++) begin
            dina_q[b]  <= '0;
            dinb_q[b]  <= '0;
            addra_q[b] <= '0;
            addrb_q[b] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lg_q    <= lg_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         we_q    <= beat;
         if (beat) begin
            for (int b = 0; b < NBANK; b++) begin
               dina_q[b]  <= dina_d[b];
               dinb_q[b]  <= dinb_d[b];
               addra_q[b] <= addra_d[b];
               addrb_q[b] <= addrb_d[b];
            end
         end
      end
   end

   assign wea_o  = {NBANK{we_q}};
   assign web_o  = {NBANK{we_q}};
   assign busy_o = busy_q;
   assign done_o = done_q;
   assign err_o  = err_q;

   generate
      for (genvar gi = 0; gi < NBANK; gi++) begin : g_out
         assign dina_o[gi*DATA_WIDTH +: DATA_WIDTH] = dina_q[gi];
         assign dinb_o[gi*DATA_WIDTH +: DATA_WIDTH] = dinb_q[gi];
         assign addra_o[gi*ADDR_W +: ADDR_W]        = addra_q[gi];
         assign addrb_o[gi*ADDR_W +: ADDR_W]        = addrb_q[gi];
      end
   endgenerate

endmodule

// File: tb/tb_bu_writeback.sv
// Randomized bench for bu_writeback against a coefficient-index reference model:
// each butterfly's top index j is derived from its ordinal, then mapped to bank j%8, row j/8.
module tb_bu_writeback;
   import ntt_pkg::*;

   logic                        clk = 1'b0;
   logic                        rst_i;
   logic                        start_i;
   logic [7:0]                  len_i;
   logic                        valid_i;
   logic [NBANK*DATA_WIDTH-1:0] x_i;
   logic [NBANK*DATA_WIDTH-1:0] y_i;
   logic [NBANK-1:0]            wea_o, web_o;
   logic [NBANK*ADDR_W-1:0]     addra_o, addrb_o;
   logic [NBANK*DATA_WIDTH-1:0] dina_o, dinb_o;
   logic                        busy_o, done_o, err_o;

   always #5 clk = ~clk;

   bu_writeback dut (
      .clk_i   (clk),
      .rst_i   (rst_i),
      .start_i (start_i),
      .len_i   (len_i),
      .valid_i (valid_i),
      .x_i     (x_i),
      .y_i     (y_i),
      .wea_o   (wea_o),
      .web_o   (web_o),
      .addra_o (addra_o),
      .addrb_o (addrb_o),
      .dina_o  (dina_o),
      .dinb_o  (dinb_o),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .err_o   (err_o)
   );

   int total = 0;
   int bad   = 0;
   int wr_cnt = 0;

   // Reference model state
   bit  mrun, merr, m_we, m_done, m_busy, m_rst;
   int  mc, mL;
   logic [NBANK*DATA_WIDTH-1:0] e_dina, e_dinb;
   logic [NBANK*ADDR_W-1:0]     e_addra, e_addrb;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int log2i(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   task automatic place(input bit pb, input int bank, input int addr, input logic [DATA_WIDTH-1:0] d);
      if (!pb) begin
         e_dina[bank*DATA_WIDTH +: DATA_WIDTH] = d;
         e_addra[bank*ADDR_W +: ADDR_W]        = 5'(addr);
      end else begin
         e_dinb[bank*DATA_WIDTH +: DATA_WIDTH] = d;
         e_addrb[bank*ADDR_W +: ADDR_W]        = 5'(addr);
      end
   endtask

   task automatic model_edge();
      int  lg, n, j, jy;
      bit  half;
      if (!rst_i) begin
         mrun = 0; merr = 0; mc = 0; m_we = 0; m_done = 0; m_busy = 0; m_rst = 1;
         e_dina = '0; e_dinb = '0; e_addra = '0; e_addrb = '0;
      end else begin
         m_rst = 0; m_we = 0; m_done = 0;
         if (!mrun) begin
            if (start_i) begin
               if (len_i inside {8'd2, 8'd4, 8'd8, 8'd16, 8'd32, 8'd64, 8'd128}) begin
                  mrun = 1; mc = 0; mL = int'(len_i); merr = 0;
               end else begin
                  merr = 1;
               end
            end
         end else if (valid_i) begin
            lg = log2i(mL);
            for (int m = 0; m < NBANK; m++) begin
               n  = 8*mc + m;
               j  = ((n >> lg) << (lg + 1)) | (n & (mL - 1));
               jy = j + mL;
               half = (m >= 4);
               if (mL >= 8) begin
                  place(1'b0, j % 8, j / 8, x_i[m*DATA_WIDTH +: DATA_WIDTH]);
                  place(1'b1, jy % 8, jy / 8, y_i[m*DATA_WIDTH +: DATA_WIDTH]);
               end else begin
                  place(half, j % 8, j / 8, x_i[m*DATA_WIDTH +: DATA_WIDTH]);
                  place(half, jy % 8, jy / 8, y_i[m*DATA_WIDTH +: DATA_WIDTH]);
               end
            end
            m_we   = 1;
            m_done = (mc == 15);
            mc++;
            if (mc == 16) mrun = 0;
         end
         m_busy = mrun || m_done;
      end
   endtask

   task automatic check_outputs();
      chk("wea", wea_o, m_we ? 8'hFF : 8'h00);
      chk("web", web_o, m_we ? 8'hFF : 8'h00);
      chk("busy", busy_o, m_busy);
      chk("done", done_o, m_done);
      chk("err", err_o, merr);
      if (m_we || m_rst) begin
         chk("addra", addra_o, e_addra);
         chk("addrb", addrb_o, e_addrb);
         chk("dina", dina_o, e_dina);
         chk("dinb", dinb_o, e_dinb);
      end
      if (wea_o !== '0) wr_cnt++;
   endtask

   task automatic step(input logic st, input logic [7:0] ln, input logic vl, input logic rs);
      start_i = st; len_i = ln; valid_i = vl; rst_i = rs;
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic rand_data();
      for (int m = 0; m < NBANK; m++) begin
         x_i[m*DATA_WIDTH +: DATA_WIDTH] = 12'($urandom_range(0, 3328));
         y_i[m*DATA_WIDTH +: DATA_WIDTH] = 12'($urandom_range(0, 3328));
      end
   endtask

   task automatic run_stage(input int L, input int gap_pct, input bit noise);
      int          beats;
      logic        st, vl;
      logic [7:0]  ln;
      $display("stage L=%0d gap=%0d noise=%0d", L, gap_pct, noise);
      step(1'b1, 8'(L), 1'b0, 1'b1);
      beats = 0;
      while (beats < 16) begin
         rand_data();
         vl = ($urandom_range(0, 99) >= gap_pct);
         st = noise && ($urandom_range(0, 7) == 0);
         ln = ($urandom_range(0, 3) == 0) ? 8'd3 : 8'(2 << $urandom_range(0, 6));
         step(st, ln, vl, 1'b1);
         if (vl) beats++;
      end
   endtask

   logic [NBANK*ADDR_W-1:0] a_exp;

   initial begin
      rst_i = 1'b0; start_i = 1'b0; len_i = '0; valid_i = 1'b0; x_i = '0; y_i = '0;
      mL = 2;

      // Reset: everything zero
      step(1'b0, 8'd0, 1'b0, 1'b0);
      step(1'b1, 8'd128, 1'b1, 1'b0);
      chk("rst_addra", addra_o, 0);
      chk("rst_busy", busy_o, 0);

      // L=128, back-to-back beats
      $display("stage L=128 directed");
      step(1'b1, 8'd128, 1'b0, 1'b1);
      chk("l128_busy_rise", busy_o, 1);
      for (int c = 0; c < 16; c++) begin
         rand_data();
         step(1'b0, 8'd0, 1'b1, 1'b1);
         if (c == 0) begin
            chk("l128_b0_addra", addra_o, 0);
            a_exp = {8{5'd16}};
            chk("l128_b0_addrb", addrb_o, a_exp);
         end
         if (c == 15) begin
            a_exp = {8{5'd15}};
            chk("l128_b15_addra", addra_o, a_exp);
            a_exp = {8{5'd31}};
            chk("l128_b15_addrb", addrb_o, a_exp);
            chk("l128_done", done_o, 1);
         end
      end
      step(1'b0, 8'd0, 1'b0, 1'b1);
      chk("l128_busy_drop", busy_o, 0);

      // L=8
      $display("stage L=8 directed");
      step(1'b1, 8'd8, 1'b0, 1'b1);
      for (int c = 0; c < 16; c++) begin
         rand_data();
         step(1'b0, 8'd0, 1'b1, 1'b1);
         if (c == 1) begin
            chk("l8_b1_addra", addra_o[3*ADDR_W +: ADDR_W], 2);
            chk("l8_b1_addrb", addrb_o[3*ADDR_W +: ADDR_W], 3);
            chk("l8_b1_dina5", dina_o[5*DATA_WIDTH +: DATA_WIDTH], x_i[5*DATA_WIDTH +: DATA_WIDTH]);
            chk("l8_b1_dinb5", dinb_o[5*DATA_WIDTH +: DATA_WIDTH], y_i[5*DATA_WIDTH +: DATA_WIDTH]);
         end
         if (c == 7) begin
            chk("l8_b7_addra", addra_o[7*ADDR_W +: ADDR_W], 14);
            chk("l8_b7_addrb", addrb_o[7*ADDR_W +: ADDR_W], 15);
         end
      end

      // L=4 started in the done cycle of the previous stage
      $display("stage L=4 directed back-to-back");
      step(1'b1, 8'd4, 1'b0, 1'b1);
      for (int c = 0; c < 16; c++) begin
         rand_data();
         if (c == 0) begin
            for (int m = 0; m < NBANK; m++) begin
               x_i[m*DATA_WIDTH +: DATA_WIDTH] = 12'(m);
               y_i[m*DATA_WIDTH +: DATA_WIDTH] = 12'(16 + m);
            end
         end
         step(1'b0, 8'd0, 1'b1, 1'b1);
         if (c == 0) begin
            chk("l4_b0_a_bank0", dina_o[0 +: DATA_WIDTH], 0);
            chk("l4_b0_a_bank4", dina_o[4*DATA_WIDTH +: DATA_WIDTH], 16);
            chk("l4_b0_b_bank0", dinb_o[0 +: DATA_WIDTH], 4);
            chk("l4_b0_b_bank4", dinb_o[4*DATA_WIDTH +: DATA_WIDTH], 20);
            chk("l4_b0_addrb4", addrb_o[4*ADDR_W +: ADDR_W], 1);
         end
      end

      // L=2
      $display("stage L=2 directed back-to-back");
      step(1'b1, 8'd2, 1'b0, 1'b1);
      for (int c = 0; c < 16; c++) begin
         rand_data();
         if (c == 3) begin
            for (int m = 0; m < NBANK; m++) begin
               x_i[m*DATA_WIDTH +: DATA_WIDTH] = 12'(100 + m);
               y_i[m*DATA_WIDTH +: DATA_WIDTH] = 12'(200 + m);
            end
         end
         step(1'b0, 8'd0, 1'b1, 1'b1);
         if (c == 3) begin
            chk("l2_b3_x2_data", dina_o[4*DATA_WIDTH +: DATA_WIDTH], 102);
            chk("l2_b3_x2_addr", addra_o[4*ADDR_W +: ADDR_W], 6);
            chk("l2_b3_y2_data", dina_o[6*DATA_WIDTH +: DATA_WIDTH], 202);
            chk("l2_b3_y2_addr", addra_o[6*ADDR_W +: ADDR_W], 6);
            chk("l2_b3_x6_data", dinb_o[4*DATA_WIDTH +: DATA_WIDTH], 106);
            chk("l2_b3_x6_addr", addrb_o[4*ADDR_W +: ADDR_W], 7);
            chk("l2_b3_y6_data", dinb_o[6*DATA_WIDTH +: DATA_WIDTH], 206);
         end
      end
      step(1'b0, 8'd0, 1'b0, 1'b1);

      // Valid gaps plus ignored starts mid-run
      wr_cnt = 0;
      run_stage(32, 60, 1'b1);
      step(1'b0, 8'd0, 1'b0, 1'b1);
      chk("gap_write_count", wr_cnt, 16);

      // Illegal length
      $display("illegal len=3");
      wr_cnt = 0;
      step(1'b1, 8'd3, 1'b0, 1'b1);
      chk("err_set", err_o, 1);
      for (int i = 0; i < 4; i++) begin
         rand_data();
         step(1'b0, 8'd0, 1'b1, 1'b1);
      end
      chk("err_no_writes", wr_cnt, 0);
      chk("err_sticky", err_o, 1);
      run_stage(16, 0, 1'b0);
      chk("err_cleared", err_o, 0);
      step(1'b0, 8'd0, 1'b0, 1'b1);

      // Reset at beat 9 of an L=32 stage
      $display("reset mid-stage L=32");
      step(1'b1, 8'd32, 1'b0, 1'b1);
      for (int c = 0; c < 9; c++) begin
         rand_data();
         step(1'b0, 8'd0, 1'b1, 1'b1);
      end
      rand_data();
      step(1'b0, 8'd0, 1'b1, 1'b0);
      chk("midrst_wea", wea_o, 0);
      chk("midrst_dina", dina_o, 0);
      wr_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         rand_data();
         step(1'b0, 8'd0, 1'b1, 1'b1);
      end
      chk("midrst_no_writes", wr_cnt, 0);

      // Random stages
      for (int s = 0; s < 12; s++) begin
         run_stage(2 << $urandom_range(0, 6), $urandom_range(0, 50), 1'b1);
         if ($urandom_range(0, 1) == 1) step(1'b0, 8'd0, 1'b1, 1'b1);
      end
      step(1'b0, 8'd0, 1'b0, 1'b1);
      step(1'b0, 8'd0, 1'b0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bu_writeback.md
# bu_writeback

Write-back router at the output of the 8-lane butterfly array in the NTT/iNTT core. Collects one beat of 8 (X, Y) butterfly results per cycle and steers each result to the correct bank, port and address of the 8 dual-port coefficient BRAMs for the current stage length. It is the store-side counterpart of the operand selector that fetches A/B operands for the butterflies. One stage is 16 beats, covering 128 butterflies and 256 coefficients.

## Interface
- DATA_WIDTH, 12, coefficient width (mod q = 3329)
- NBANK, 8, BRAM banks = butterfly lanes (fixed)
- ADDR_W, 5, per-bank address width (32 words/bank)
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  synchronous, active-low reset
- start_i  in  1  begin stage; samples len_i
- len_i  in  8  stage length L ∈ {2,4,8,16,32,64,128}
- valid_i  in  1  x_i/y_i hold one valid beat
- x_i  in  NBANK×DATA_WIDTH  butterfly X outputs, lane m
- y_i  in  NBANK×DATA_WIDTH  butterfly Y outputs, lane m
- wea_o / web_o  out  NBANK  per-bank port A/B write enable
- addra_o / addrb_o  out  NBANK×ADDR_W  per-bank port A/B address
- dina_o / dinb_o  out  NBANK×DATA_WIDTH  per-bank port A/B write data
- busy_o  out  1  stage in progress
- done_o  out  1  one-cycle pulse with last write
- err_o  out  1  sticky: illegal len_i at start; cleared by next legal start

## Operation
- Coefficient j lives at bank j[2:0], address j[7:3]. Butterfly pairs are (j, j+L) with bit log2(L) of j equal to 0.
- FSM states: IDLE, RUN.
  - IDLE: on start_i with legal len_i, latch L, clear beat counter c (4 bit), go to RUN.
  - On start_i with illegal len_i, set err_o, stay IDLE, no writes.
  - RUN: each valid_i cycle is one beat. c increments. Beat c = 15 returns FSM to IDLE.
  - start_i while in RUN is ignored.
- Mapping, L ≥ 8 (g = L/8):
  - Lane k writes bank k only.
  - Address a = (c/g)·2g + (c mod g).
  - Port A: addr a, data x[k]. Port B: addr a+g, data y[k].
- Mapping, L ∈ {2,4}:
  - Lanes 0–3 cover row 2c on port A; lanes 4–7 cover row 2c+1 on port B.
  - Lane m's lower bank p(m mod 4):
    - L=4: p = {0,1,2,3}
    - L=2: p = {0,1,4,5}
  - X goes to bank p, Y goes to bank p+L, both at the row address on that lane's port.
- Every beat writes all 16 bank-ports exactly once: wea_o = web_o = 8'hFF.
- No arithmetic on data; values pass unmodified. Forward and inverse transforms use the same mapping; only the caller's L sequence differs.

## Timing
- All outputs registered. Beat accepted at edge t → writes presented in cycle t+1, for one cycle.
- valid_i gaps allowed: cycles without valid_i drive wea_o/web_o = 0 and leave c unchanged.
- busy_o rises the cycle after a legal start and falls the cycle after the 16th write is presented.
- done_o is high in the same cycle as the 16th write.
- valid_i in IDLE is ignored; no write.
- Reset (rst_i = 0 at an edge): FSM goes to IDLE, c = 0. All outputs are 0: enables, addresses, data, busy_o, done_o, err_o. Reset in mid-stage aborts it and suppresses any pending write.
- Back-to-back stages: start_i may be asserted in the cycle done_o is high. The new stage's first write can appear 2 cycles after its start edge.

## Structure
- ntt_pkg holds:
  - DATA_WIDTH, NBANK, ADDR_W, BEATS = 16
  - coeff_t typedef
  - the FSM state enum
  - the legal-L check function
- Sub-module bu_wb_addr_gen: combinational map from (L, c, lane) to {bank, port, addr} for X and Y.
- The top level holds the FSM, the counter and the registered crossbar.

## Test plan
- L=128, 16 consecutive beats → beat 0: every bank addra 0 / addrb 16. Beat 15: addra 15 / addrb 31. done_o with beat-15 write; busy_o drops next cycle.
- L=8 → beat 0: addra 0 / addrb 1. Beat 1: addra 2 / addrb 3. Beat 7: addra 14 / addrb 15. Port data equals x[k]/y[k].
- L=4, beat 0, x[m]=m, y[m]=16+m:
  - bank0 A=0, bank4 A=16 (addr 0)
  - bank0 B=4, bank4 B=20 (addr 1)
- L=2, beat 3, lane 2 → x[2] to bank4 port A addr 6, y[2] to bank6 port A addr 6. Lane 6 → port B addr 7.
- Valid gaps: 16 beats spread over 40 cycles → exactly 16 write cycles, no enables in gaps. start_i mid-run is ignored.
- len_i=3 → err_o=1, no writes. rst_i=0 at beat 9 of an L=32 stage → all outputs 0 next cycle, no further writes.
